// File: rtl/stdp_pkg.sv
// stdp_pkg: STDP case indices, LFSR polynomial/seed, and a case-conflict helper.
package stdp_pkg;
  localparam int CASE_CAPTURE = 0;
  localparam int CASE_MINUS = 1;
  localparam int CASE_SEARCH = 2;
  localparam int CASE_BACKOFF = 3;
  // Galois right-shift taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  function automatic logic multi_case(input logic [3:0] c);
    return (c & (c - 4'd1)) != 4'd0;
  endfunction
endpackage

// File: rtl/stdp_weight_update_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reloaded with seed on rst.
module lfsr16
  import stdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= seed;
    else q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_POLY : 16'h0000);
endmodule

// File: rtl/stdp_weight_update.sv
// stdp_weight_update: two-stage STDP synaptic weight update with load override.
// Define STDP_STOCHASTIC_EN to gate updates by an LFSR against per-case MU probabilities.
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int          WRES       = 3,
  parameter logic [8:0]  MU_CAPTURE = 9'd256,
  parameter logic [8:0]  MU_MINUS   = 9'd256,
  parameter logic [8:0]  MU_SEARCH  = 9'd256,
  parameter logic [8:0]  MU_BACKOFF = 9'd256,
  parameter logic [15:0] LFSR_SEED  = LFSR_DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            grst,
  input  logic [3:0]      stdp_cases,
  input  logic            load_en,
  input  logic [WRES-1:0] load_w,
  output logic [WRES-1:0] weight,
  output logic            weight_upd,
  output logic            case_err
);
  localparam logic [WRES-1:0] WMAX = '1;
  if (LFSR_SEED == 16'h0000 || MU_CAPTURE > 9'd256 || MU_MINUS > 9'd256 ||
      MU_SEARCH > 9'd256 || MU_BACKOFF > 9'd256) begin : g_bad_cfg
    $error("stdp_weight_update: LFSR_SEED must be nonzero and MU values <= 256");
  end
  logic [3:0]      r_case;
  logic            r_valid;
  logic [WRES-1:0] r_weight;
  logic            r_upd;
  logic            r_err;
  logic            w_inc;
  logic            w_dec;
  logic [WRES-1:0] w_next;
  logic            w_fire;
  logic            w_chg;
  assign w_inc = r_case[CASE_CAPTURE] | r_case[CASE_SEARCH];
  assign w_dec = r_case[CASE_MINUS] | r_case[CASE_BACKOFF];
  assign w_next = w_inc ? ((r_weight == WMAX) ? r_weight : r_weight + 1'b1)
                : w_dec ? ((r_weight == '0) ? r_weight : r_weight - 1'b1)
                : r_weight;
`ifdef STDP_STOCHASTIC_EN
  logic [15:0] w_lfsr;
  logic [8:0]  w_mu;
  lfsr16 u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .q(w_lfsr));
  assign w_mu = r_case[CASE_CAPTURE] ? MU_CAPTURE
              : r_case[CASE_MINUS]   ? MU_MINUS
              : r_case[CASE_SEARCH]  ? MU_SEARCH
              : MU_BACKOFF;
  assign w_fire = {1'b0, w_lfsr[7:0]} < w_mu;
`else
  assign w_fire = 1'b1;
`endif
  // Conflicting or empty case sets never move the weight; only real changes pulse.
  assign w_chg = r_valid & $onehot(r_case) & w_fire & (w_next != r_weight);
  always_ff @(posedge clk)
    if (rst) begin
      r_case   <= '0;
      r_valid  <= 1'b0;
      r_weight <= '0;
      r_upd    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= grst;
      if (grst) r_case <= stdp_cases;
      r_err <= r_err | (grst & multi_case(stdp_cases));
      r_upd <= ~load_en & w_chg;
      if (load_en) r_weight <= load_w;
      else if (w_chg) r_weight <= w_next;
    end
  assign weight = r_weight;
  assign weight_upd = r_upd;
  assign case_err = r_err;
endmodule

// File: tb/tb_stdp_weight_update.sv
// tb_stdp_weight_update: directed and randomized checks against a delay-line reference model.
module tb_stdp_weight_update;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       grst = 1'b0;
  logic [3:0] stdp_cases = '0;
  logic       load_en = 1'b0;
  logic [2:0] load_w = '0;
  logic [2:0] weight;
  logic       weight_upd;
  logic       case_err;
  int total = 0;
  int bad = 0;
  int m_w = 0;
  bit m_upd = 0;
  bit m_err = 0;
  int delay_q[$];

  always #5 clk = ~clk;

  stdp_weight_update dut (
    .clk(clk), .rst(rst), .grst(grst), .stdp_cases(stdp_cases),
    .load_en(load_en), .load_w(load_w),
    .weight(weight), .weight_upd(weight_upd), .case_err(case_err)
  );

  task automatic cyc(input bit r, input bit g, input logic [3:0] c, input bit ld, input logic [2:0] lw);
    int e;
    int nw;
    rst = r; grst = g; stdp_cases = c; load_en = ld; load_w = lw;
    @(posedge clk);
    #1;
    rst = 0; grst = 0; stdp_cases = '0; load_en = 0;
    if (r) begin
      m_w = 0; m_upd = 0; m_err = 0;
      delay_q = {-1};
    end else begin
      e = delay_q.pop_front();
      delay_q.push_back(g ? int'(c) : -1);
      m_upd = 0;
      if (g && $countones(c) > 1) m_err = 1;
      if (ld) m_w = int'(lw);
      else if (e >= 0 && $countones(e[3:0]) == 1) begin
        nw = (e[0] || e[2]) ? ((m_w < 7) ? m_w + 1 : 7) : ((m_w > 0) ? m_w - 1 : 0);
        m_upd = (nw != m_w);
        m_w = nw;
      end
    end
  endtask

  task automatic test_reset;
    cyc(1, 1, 4'b0101, 1, 3'd5);
    cyc(1, 1, 4'b0001, 1, 3'd6);
    total++; if (weight !== 3'd0) begin bad++; $display("FAIL reset_weight got=%0d exp=0", weight); end
    total++; if (weight_upd !== 1'b0) begin bad++; $display("FAIL reset_upd got=%b exp=0", weight_upd); end
    total++; if (case_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", case_err); end
    cyc(0, 0, 4'b0000, 0, 3'd0);
    cyc(0, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd0 || weight_upd !== 1'b0) begin bad++; $display("FAIL reset_hold got=%0d/%b exp=0/0", weight, weight_upd); end
  endtask

  task automatic test_capture_timing;
    cyc(0, 0, 4'b0000, 1, 3'd3);
    cyc(0, 1, 4'b0001, 0, 3'd0);
    total++; if (weight !== 3'd3 || weight_upd !== 1'b0) begin bad++; $display("FAIL cap_n1 got=%0d/%b exp=3/0", weight, weight_upd); end
    cyc(0, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd4 || weight_upd !== 1'b1) begin bad++; $display("FAIL cap_n2 got=%0d/%b exp=4/1", weight, weight_upd); end
    cyc(0, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd4 || weight_upd !== 1'b0) begin bad++; $display("FAIL cap_n3 got=%0d/%b exp=4/0", weight, weight_upd); end
  endtask

  task automatic test_saturation;
    int ups;
    ups = 0;
    cyc(0, 0, 4'b0000, 1, 3'd7);
    for (int i = 0; i < 7; i++) begin
      cyc(0, i < 5, 4'b0001, 0, 3'd0);
      ups += int'(weight_upd);
      total++; if (weight !== 3'd7) begin bad++; $display("FAIL sat_max[%0d] got=%0d exp=7", i, weight); end
    end
    total++; if (ups != 0) begin bad++; $display("FAIL sat_max_upd got=%0d exp=0", ups); end
    cyc(0, 0, 4'b0000, 1, 3'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, i < 5, 4'b1000, 0, 3'd0);
      ups += int'(weight_upd);
      total++; if (weight !== 3'd0) begin bad++; $display("FAIL sat_min[%0d] got=%0d exp=0", i, weight); end
    end
    total++; if (ups != 0) begin bad++; $display("FAIL sat_min_upd got=%0d exp=0", ups); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] seq [3];
    logic [2:0] exp_w [3];
    seq = '{4'b0100, 4'b0100, 4'b0010};
    exp_w = '{3'd3, 3'd4, 3'd3};
    cyc(0, 0, 4'b0000, 1, 3'd2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, i < 3, (i < 3) ? seq[i] : 4'b0000, 0, 3'd0);
      if (i >= 1 && i <= 3) begin
        total++;
        if (weight !== exp_w[i-1] || weight_upd !== 1'b1) begin
          bad++; $display("FAIL b2b[%0d] got=%0d/%b exp=%0d/1", i - 1, weight, weight_upd, exp_w[i-1]);
        end
      end
    end
  endtask

  task automatic test_case_err;
    cyc(0, 0, 4'b0000, 1, 3'd5);
    cyc(0, 1, 4'b0101, 0, 3'd0);
    total++; if (case_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", case_err); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, i == 1, 4'b0000, 0, 3'd0);
      total++;
      if (weight !== 3'd5 || weight_upd !== 1'b0 || case_err !== 1'b1) begin
        bad++; $display("FAIL err_hold[%0d] got=%0d/%b/%b exp=5/0/1", i, weight, weight_upd, case_err);
      end
    end
    cyc(1, 0, 4'b0000, 0, 3'd0);
    total++; if (case_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", case_err); end
  endtask

  task automatic test_load_priority;
    cyc(0, 0, 4'b0000, 1, 3'd2);
    cyc(0, 1, 4'b0001, 0, 3'd0);
    cyc(0, 0, 4'b0000, 1, 3'd5);
    total++; if (weight !== 3'd5 || weight_upd !== 1'b0) begin bad++; $display("FAIL load_prio got=%0d/%b exp=5/0", weight, weight_upd); end
    cyc(0, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd5 || weight_upd !== 1'b0) begin bad++; $display("FAIL load_after got=%0d/%b exp=5/0", weight, weight_upd); end
    cyc(0, 1, 4'b0001, 0, 3'd0);
    cyc(1, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd0) begin bad++; $display("FAIL rst_mid got=%0d exp=0", weight); end
    cyc(0, 0, 4'b0000, 0, 3'd0);
    total++; if (weight !== 3'd0 || weight_upd !== 1'b0) begin bad++; $display("FAIL rst_drop got=%0d/%b exp=0/0", weight, weight_upd); end
  endtask

  task automatic test_random;
    logic [3:0] c;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ($urandom_range(0, 9) == 0 ? 4'b0000 : 4'(1 << $urandom_range(0, 3)));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, c, $urandom_range(0, 7) == 0, 3'($urandom));
      total++;
      if (weight !== 3'(m_w) || weight_upd !== m_upd || case_err !== m_err) begin
        bad++; $display("FAIL rand[%0d] got=%0d/%b/%b exp=%0d/%b/%b", i, weight, weight_upd, case_err, m_w, m_upd, m_err);
      end
    end
  endtask

`ifdef STDP_STOCHASTIC_EN
  logic       s_rst = 1'b0;
  logic       s_grst = 1'b0;
  logic [3:0] s_cases = '0;
  logic       s_ld = 1'b0;
  logic [2:0] s_lw = '0;
  logic [2:0] s_weight;
  logic       s_upd;
  logic       s_err;
  stdp_weight_update #(.MU_CAPTURE(9'd64), .MU_MINUS(9'd0)) u_sto (
    .clk(clk), .rst(s_rst), .grst(s_grst), .stdp_cases(s_cases),
    .load_en(s_ld), .load_w(s_lw),
    .weight(s_weight), .weight_upd(s_upd), .case_err(s_err)
  );

  task automatic test_stochastic;
    int n;
    s_rst = 1; @(posedge clk); #1; s_rst = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int i = 0; i < ((k == 0) ? 4096 : 512); i++) begin
        s_ld = 1; s_lw = (k == 0) ? 3'd0 : 3'd7;
        @(posedge clk); #1;
        s_ld = 0; s_grst = 1; s_cases = (k == 0) ? 4'b0001 : 4'b0010;
        @(posedge clk); #1;
        s_grst = 0; s_cases = '0;
        @(posedge clk); #1;
        n += int'(s_upd);
      end
      total++;
      if (k == 0 && (n < 928 || n > 1120)) begin bad++; $display("FAIL sto_mu64 got=%0d exp=1024+-96", n); end
      if (k == 1 && n != 0) begin bad++; $display("FAIL sto_mu0 got=%0d exp=0", n); end
    end
  endtask
`endif

  initial begin
    delay_q = {-1};
    test_reset();
    test_capture_timing();
    test_saturation();
    test_back_to_back();
    test_case_err();
    test_load_priority();
    test_random();
`ifdef STDP_STOCHASTIC_EN
    test_stochastic();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
